// File: rtl/irq_ctl_if.sv
// irq_ctl_if: 65C02 core address/write-data/read-data bus as seen by a memory-mapped responder
interface irq_ctl_if;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  modport master (output AB, DO, WE, input DI);
  modport slave (input AB, DO, WE, output DI);
endinterface

// File: rtl/irq_ctl.sv
// irq_ctl: 8-source interrupt controller on the 65C02 bus; define IRQ_CTL_EDGE_EN for the MODE register and edge detection
module irq_ctl #(
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic       clk,
  input  logic       reset,
  irq_ctl_if.slave   bus,
  input  logic [7:0] src,
  output logic       irq
);
  logic [7:0] sync_q, s_q, pending_q, pending_d, mask_q, di_q, di_d;
  logic [7:0] mode, set, clr, act, vec;
  logic [2:0] idx;
  logic [1:0] a;
  logic       irq_q, sel, wr;
  assign sel = bus.AB[15:2] == BASE[15:2];
  assign a = bus.AB[1:0];
  assign wr = sel & bus.WE;
  assign clr = (wr && a == 2'd0) ? bus.DO : 8'h00;
  assign act = pending_q & mask_q;
`ifdef IRQ_CTL_EDGE_EN
  logic [7:0] s_d_q, mode_q;
  assign mode = mode_q;
  assign set = s_q & ~(mode_q & s_d_q);
  // previous synchronized level for edge detection, and the MODE register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s_d_q <= 8'h00;
      mode_q <= 8'h00;
    end else begin
      s_d_q <= s_q;
      if (wr && a == 2'd3) mode_q <= bus.DO;
    end
`else
  assign mode = 8'h00;
  assign set = s_q;
`endif
  // lowest enabled pending source wins the vector
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (act[i]) idx = 3'(i);
  end
  assign vec = {|act, 4'b0000, idx};
  // set is OR-ed after the clear so a fresh event survives a simultaneous W1C
  assign pending_d = (pending_q & ~clr) | set;
  assign di_d = !(sel && !bus.WE) ? 8'h00 :
                a == 2'd0 ? pending_q :
                a == 2'd1 ? mask_q :
                a == 2'd2 ? vec : mode;
  // synchronizer, pending/mask state and registered bus/irq outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= 8'h00;
      s_q <= 8'h00;
      pending_q <= 8'h00;
      mask_q <= 8'h00;
      di_q <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      sync_q <= src;
      s_q <= sync_q;
      pending_q <= pending_d;
      if (wr && a == 2'd1) mask_q <= bus.DO;
      di_q <= di_d;
      irq_q <= |act;
    end
  assign bus.DI = di_q;
  assign irq = irq_q;
endmodule
